// File: rtl/df_coeff_loader.sv
// ============================================================================
// Module   : df_coeff_loader
// Purpose  : Serial coefficient loader with atomic commit of a shadow bank onto
//            the direct-form-I filter's packed coefficient bus.
// Options  : DF_COEFF_DEFAULT_EN - reset to an identity set (h[0] = 2^Q).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module df_coeff_loader #(
    parameter int N           = 3,
    parameter int COEFF_WIDTH = 16,
    parameter int Q           = 14,
    parameter int GEN_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_start,
    input  logic                           coeff_valid,
    output logic                           coeff_ready,
    input  logic [COEFF_WIDTH-1:0]         coeff_data,
    input  logic                           commit_en,
    output logic [COEFF_WIDTH*(N+1)-1:0]   packed_coeffs,
    output logic                           busy,
    output logic                           load_done,
    output logic                           overrun,
    output logic [GEN_WIDTH-1:0]           bank_gen
);

    localparam int c_bank_w = COEFF_WIDTH * (N + 1);
    localparam int c_idx_w  = (N > 0) ? $clog2(N + 1) : 1;

`ifdef DF_COEFF_DEFAULT_EN
    localparam bit c_default_en = 1'b1;

    if (Q >= COEFF_WIDTH - 1) begin : g_q_range_check
        $error("df_coeff_loader: Q must be smaller than COEFF_WIDTH-1");
    end
`else
    localparam bit c_default_en = 1'b0;
`endif

    localparam logic [COEFF_WIDTH-1:0] c_identity_h0 = COEFF_WIDTH'(1) << Q;
    localparam logic [c_bank_w-1:0]    c_reset_bank  =
        c_default_en ? c_bank_w'(c_identity_h0) : '0;
    localparam logic [c_idx_w-1:0]     c_idx_last    = c_idx_w'(N);
    localparam logic [c_idx_w-1:0]     c_idx_one     = c_idx_w'(1);
    localparam logic [GEN_WIDTH-1:0]   c_gen_one     = GEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD        = 2'd1,
        ST_WAIT_COMMIT = 2'd2
    } state_t;

    state_t                   r_state;
    logic [c_idx_w-1:0]       r_index;
    logic [COEFF_WIDTH-1:0]   r_shadow [0:N];
    logic [c_bank_w-1:0]      r_packed;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_overrun;
    logic [GEN_WIDTH-1:0]     r_gen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_index   <= '0;
            r_packed  <= c_reset_bank;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_gen     <= '0;
            for (int k = 0; k <= N; k++) begin
                r_shadow[k] <= c_reset_bank[COEFF_WIDTH*k +: COEFF_WIDTH];
            end
        end else begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_index <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // A restart wins over a beat presented in the same cycle.
                    if (load_start) begin
                        r_overrun <= 1'b1;
                        r_index   <= '0;
                    end else if (coeff_valid) begin
                        r_shadow[r_index] <= coeff_data;
                        if (r_index == c_idx_last) begin
                            r_state <= ST_WAIT_COMMIT;
                            r_ready <= 1'b0;
                        end else begin
                            r_index <= r_index + c_idx_one;
                        end
                    end
                end
                ST_WAIT_COMMIT: begin
                    if (commit_en) begin
                        for (int k = 0; k <= N; k++) begin
                            r_packed[COEFF_WIDTH*k +: COEFF_WIDTH] <= r_shadow[k];
                        end
                        r_gen  <= r_gen + c_gen_one;
                        r_done <= 1'b1;
                    end
                    // A restart coinciding with the commit is not an overrun:
                    // the previous set has just been delivered.
                    if (load_start) begin
                        r_overrun <= !commit_en;
                        r_state   <= ST_LOAD;
                        r_index   <= '0;
                        r_ready   <= 1'b1;
                    end else if (commit_en) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign coeff_ready   = r_ready;
    assign packed_coeffs = r_packed;
    assign busy          = r_busy;
    assign load_done     = r_done;
    assign overrun       = r_overrun;
    assign bank_gen      = r_gen;

endmodule

`default_nettype wire

// File: tb/tb_df_coeff_loader.sv
// ============================================================================
// Module   : tb_df_coeff_loader
// Purpose  : Directed self-checking bench for df_coeff_loader with a
//            queue-based reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_df_coeff_loader;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int GW = 8;
    localparam int BW = W * (N + 1);

`ifdef DF_COEFF_DEFAULT_EN
    localparam logic [BW-1:0] c_reset_bank = 64'h0000_0000_0000_4000;
`else
    localparam logic [BW-1:0] c_reset_bank = 64'h0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0;
    logic          coeff_valid = 1'b0;
    logic          coeff_ready;
    logic [W-1:0]  coeff_data = '0;
    logic          commit_en = 1'b0;
    logic [BW-1:0] packed_coeffs;
    logic          busy;
    logic          load_done;
    logic          overrun;
    logic [GW-1:0] bank_gen;

    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;
    int over_seen = 0;

    df_coeff_loader #(.N(N), .COEFF_WIDTH(W), .Q(14), .GEN_WIDTH(GW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .coeff_data(coeff_data), .commit_en(commit_en),
        .packed_coeffs(packed_coeffs), .busy(busy), .load_done(load_done),
        .overrun(overrun), .bank_gen(bank_gen)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = collecting words, 2 = holding a full set.
    int            m_phase;
    logic [W-1:0]  m_words[$];
    logic [BW-1:0] m_packed;
    int            m_gen;
    bit            m_done;
    bit            m_over;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  = 0;
            m_words.delete();
            m_packed = c_reset_bank;
            m_gen    = 0;
            m_done   = 0;
            m_over   = 0;
        end else begin
            m_done = 0;
            m_over = 0;
            if (m_phase == 2 && commit_en) begin
                for (int k = 0; k <= N; k++) m_packed[W*k +: W] = m_words[k];
                m_gen  = (m_gen + 1) % (1 << GW);
                m_done = 1;
                m_words.delete();
                m_phase = load_start ? 1 : 0;
            end else if (load_start) begin
                m_over = (m_phase != 0);
                m_words.delete();
                m_phase = 1;
            end else if (m_phase == 1 && coeff_valid) begin
                m_words.push_back(coeff_data);
                if (m_words.size() == N + 1) m_phase = 2;
            end
        end
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("packed_coeffs", packed_coeffs, m_packed);
        check("coeff_ready", BW'(coeff_ready), BW'(m_phase == 1));
        check("busy", BW'(busy), BW'(m_phase != 0));
        check("load_done", BW'(load_done), BW'(m_done));
        check("overrun", BW'(overrun), BW'(m_over));
        check("bank_gen", BW'(bank_gen), BW'(m_gen));
        if (load_done === 1'b1) done_seen++;
        if (overrun === 1'b1) over_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] d);
        coeff_valid = 1'b1;
        coeff_data  = d;
        tick();
        coeff_valid = 1'b0;
    endtask

    task automatic commit_pulse();
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [W-1:0] set3 [4];
        int done_base;

        // 1: reset state
        do_reset();
        check("reset packed", packed_coeffs, c_reset_bank);
        check("reset gen", BW'(bank_gen), '0);

        // 2: straight load, commit a few cycles later
        pulse_start();
        send_word(16'h1111); send_word(16'h2222);
        send_word(16'h3333); send_word(16'h4444);
        tick(); tick();
        commit_pulse();
        tick();
        check("t2 packed", packed_coeffs, 64'h4444_3333_2222_1111);
        check("t2 gen", BW'(bank_gen), BW'(1));

        // 3: gapped valid, commit_en held high throughout
        set3 = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
        commit_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            coeff_valid = (i % 2 == 0);
            coeff_data  = (i % 2 == 0) ? set3[i/2] : 16'hFFFF;
            if (i == 7) check("t3 old kept", packed_coeffs, 64'h4444_3333_2222_1111);
            tick();
        end
        coeff_valid = 1'b0;
        commit_en   = 1'b0;
        tick();
        check("t3 packed", packed_coeffs, 64'h8888_7777_6666_5555);
        check("t3 gen", BW'(bank_gen), BW'(2));

        // 4: restart after two beats; beat in the restart cycle is dropped
        over_seen = 0;
        pulse_start();
        send_word(16'h1234); send_word(16'h5678);
        load_start = 1'b1; coeff_valid = 1'b1; coeff_data = 16'h9999;
        tick();
        load_start = 1'b0; coeff_valid = 1'b0;
        send_word(16'hAAAA); send_word(16'hBBBB);
        send_word(16'hCCCC); send_word(16'hDDDD);
        commit_pulse();
        tick();
        check("t4 packed", packed_coeffs, 64'hDDDD_CCCC_BBBB_AAAA);
        check("t4 overrun count", BW'(over_seen), BW'(1));

        // 7: restart coincident with commit is not an overrun
        pulse_start();
        send_word(16'h0001); send_word(16'h0002);
        send_word(16'h0003); send_word(16'h8004);
        load_start = 1'b1; commit_en = 1'b1;
        tick();
        load_start = 1'b0; commit_en = 1'b0;
        check("t7 packed", packed_coeffs, 64'h8004_0003_0002_0001);
        send_word(16'hFFFE); send_word(16'h0010);
        send_word(16'h7FFF); send_word(16'h8000);
        commit_pulse();
        tick();
        check("t7 packed2", packed_coeffs, 64'h8000_7FFF_0010_FFFE);
        check("t7 overrun count", BW'(over_seen), BW'(1));

        // 5: reset in the middle of a load
        pulse_start();
        send_word(16'h0A0A); send_word(16'h0B0B); send_word(16'h0C0C);
        #2 rst = 1'b1;
        #2 check("t5 async packed", packed_coeffs, c_reset_bank);
        check("t5 async ready", BW'(coeff_ready), '0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        send_word(16'h0101); send_word(16'h0202);
        send_word(16'h0303); send_word(16'h0404);
        commit_pulse();
        tick();
        check("t5 packed", packed_coeffs, 64'h0404_0303_0202_0101);
        check("t5 gen", BW'(bank_gen), BW'(1));

        // 6: generation counter wraps after 256 commits
        do_reset();
        done_base = done_seen;
        for (int j = 0; j < 256; j++) begin
            pulse_start();
            for (int k = 0; k <= N; k++) send_word(W'(j * 4 + k));
            commit_pulse();
        end
        tick();
        check("t6 gen wrap", BW'(bank_gen), '0);
        check("t6 done count", BW'(done_seen - done_base), BW'(256));
        check("t6 last set", packed_coeffs, 64'h03FF_03FE_03FD_03FC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
